// File: rtl/mux_rr_sched.sv
// Round-robin scheduler sharing one inverting 4:1 MUXX between four requesters.
// Optional macro MUX_SCHED_PRIO0_EN: requester 0 gets fixed top priority.
module mux_rr_sched #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] REQ,
  input  logic       NOTY,
  output logic       A0,
  output logic       A1,
  output logic [3:0] GNT,
  output logic       BUSY,
  output logic       Y_VALID,
  output logic       Y_OUT,
  output logic [1:0] Y_SRC
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       pri_q, pri_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             yv_q, yv_d;
  logic             yout_q, yout_d;
  logic [1:0]       ysrc_q, ysrc_d;

  logic [1:0]       win;
  logic [1:0]       idx;
  logic             found;

  // Pick the first requester at or after the priority pointer
  always_comb begin
    win   = 2'd0;
    idx   = 2'd0;
    found = 1'b0;
`ifdef MUX_SCHED_PRIO0_EN
    if (REQ[0]) begin
      found = 1'b1;
    end
    for (int k = 0; k < 4; k++) begin
      idx = pri_q + 2'(k);
      if (!found && idx != 2'd0 && REQ[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
`else
    for (int k = 0; k < 4; k++) begin
      idx = pri_q + 2'(k);
      if (!found && REQ[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
`endif
  end

  // Next-state and output decode for the service sequence
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pri_d   = pri_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    yv_d    = 1'b0;
    yout_d  = yout_q;
    ysrc_d  = ysrc_q;
    unique case (state_q)
      S_IDLE: begin
        if (|REQ) begin
          sel_d   = win;
          gnt_d   = 4'b0001 << win;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_CAPTURE: begin
        yout_d  = ~NOTY;
        ysrc_d  = sel_q;
        yv_d    = 1'b1;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
`ifdef MUX_SCHED_PRIO0_EN
        if (sel_q != 2'd0) begin
          pri_d = sel_q + 2'd1;
        end
`else
        pri_d   = sel_q + 2'd1;
`endif
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pri_q   <= 2'd0;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      busy_q  <= 1'b0;
      yv_q    <= 1'b0;
      yout_q  <= 1'b0;
      ysrc_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pri_q   <= pri_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      yv_q    <= yv_d;
      yout_q  <= yout_d;
      ysrc_q  <= ysrc_d;
    end
  end

  assign A0      = sel_q[0];
  assign A1      = sel_q[1];
  assign GNT     = gnt_q;
  assign BUSY    = busy_q;
  assign Y_VALID = yv_q;
  assign Y_OUT   = yout_q;
  assign Y_SRC   = ysrc_q;

endmodule

// File: tb/tb_mux_rr_sched.sv
// Scoreboard bench for mux_rr_sched: main instance (settle 2) plus
// a settle-1 instance for the capture-edge boundary.
module tb_mux_rr_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] d   = 4'b0000;
  logic       noty;
  logic       a0, a1, busy, y_valid, y_out;
  logic [3:0] gnt;
  logic [1:0] y_src;

  logic [3:0] req1  = 4'b0000;
  logic       noty1 = 1'b1;
  logic       a0_1, a1_1, busy1, y_valid1, y_out1;
  logic [3:0] gnt1;
  logic [1:0] y_src1;

  int checks = 0;
  int errors = 0;

  logic [2:0] sb[$];
  logic [2:0] exp_r;

  always #5 clk = ~clk;

  // Behavioural inverting mux
  assign noty = ~d[{a1, a0}];

  mux_rr_sched #(.SETTLE_CYCLES(2), .CNT_W(4)) u_dut (
    .CLK(clk), .RST(rst), .REQ(req), .NOTY(noty),
    .A0(a0), .A1(a1), .GNT(gnt), .BUSY(busy),
    .Y_VALID(y_valid), .Y_OUT(y_out), .Y_SRC(y_src)
  );

  mux_rr_sched #(.SETTLE_CYCLES(1), .CNT_W(4)) u_dut1 (
    .CLK(clk), .RST(rst), .REQ(req1), .NOTY(noty1),
    .A0(a0_1), .A1(a1_1), .GNT(gnt1), .BUSY(busy1),
    .Y_VALID(y_valid1), .Y_OUT(y_out1), .Y_SRC(y_src1)
  );

  // Result monitor: every pulse must match the oldest expectation
  always @(negedge clk) begin
    if (y_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result src=%0d out=%0d",
                 y_src, y_out);
      end else begin
        exp_r = sb.pop_front();
        if ({y_src, y_out} !== exp_r) begin
          errors++;
          $display("FAIL result got src=%0d out=%0d exp src=%0d out=%0d",
                   y_src, y_out, exp_r[2:1], exp_r[0]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      cyc++;
      if (y_valid) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int pulses;
    rst = 1'b1;
    tick(2);
    checks++;
    if ({a1, a0, gnt, busy, y_valid, y_out, y_src} !== 11'd0) begin
      errors++;
      $display("FAIL reset_init got %b exp 0",
               {a1, a0, gnt, busy, y_valid, y_out, y_src});
    end
    rst = 1'b0;
    req = 4'b1111;
    tick(2);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy_pre got %b exp 1", busy);
    end
    rst = 1'b1;
    tick(2);
    checks++;
    if ({a1, a0} !== 2'b00 || gnt !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_sel got a=%b gnt=%b exp 0",
               {a1, a0}, gnt);
    end
    checks++;
    if (busy !== 1'b0 || y_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_busy got busy=%b yv=%b exp 0",
               busy, y_valid);
    end
    rst = 1'b0;
    req = 4'b0000;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (y_valid) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_abort got %0d pulses exp 0", pulses);
    end
  endtask

  task automatic test_single();
    d = 4'b0100;
    sb.push_back({2'd2, 1'b1});
    req = 4'b0100;
    tick(1);
    checks++;
    if (gnt !== 4'b0100 || {a1, a0} !== 2'b10 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant got gnt=%b a=%b busy=%b exp 0100 10 1",
               gnt, {a1, a0}, busy);
    end
    req = 4'b0000;
    tick(2);
    checks++;
    if (y_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early got yv=%b exp 0", y_valid);
    end
    tick(1);
    checks++;
    if (y_valid !== 1'b1 || y_out !== 1'b1 || y_src !== 2'd2) begin
      errors++;
      $display("FAIL single_result got yv=%b out=%b src=%0d exp 1 1 2",
               y_valid, y_out, y_src);
    end
    tick(1);
    checks++;
    if (y_valid !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b0 ||
        y_out !== 1'b1) begin
      errors++;
      $display("FAIL single_after got yv=%b gnt=%b busy=%b out=%b",
               y_valid, gnt, busy, y_out);
    end
  endtask

  task automatic test_round_robin();
    int cyc;
    bit ok;
    logic [1:0] s;
    do_reset();
    d = 4'b1010;
    for (int r = 0; r < 5; r++) begin
      s = 2'(r);
      sb.push_back({s, d[s]});
    end
    req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      wait_valid(cyc, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rr_timeout round=%0d", r);
      end else if (cyc != 4) begin
        errors++;
        $display("FAIL rr_spacing round=%0d got %0d exp 4", r, cyc);
      end
    end
    req = 4'b0000;
    tick(2);
  endtask

  task automatic test_req_drop();
    int pulses;
    d = 4'b1010;
    sb.push_back({2'd1, 1'b1});
    req = 4'b0010;
    tick(1);
    req = 4'b0000;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (y_valid) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL drop_pulses got %0d exp 1", pulses);
    end
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || y_src !== 2'd1) begin
      errors++;
      $display("FAIL drop_idle got gnt=%b busy=%b src=%0d exp 0 0 1",
               gnt, busy, y_src);
    end
  endtask

  task automatic test_settle_boundary();
    for (int r = 0; r < 2; r++) begin
      noty1 = (r == 0);
      req1  = 4'b0001;
      tick(1);
      req1 = 4'b0000;
      tick(1);
      checks++;
      if (y_valid1 !== 1'b0) begin
        errors++;
        $display("FAIL settle_early round=%0d got yv=%b exp 0",
                 r, y_valid1);
      end
      noty1 = ~noty1;
      tick(1);
      checks++;
      if (y_valid1 !== 1'b1 || y_out1 !== ~noty1 || y_src1 !== 2'd0) begin
        errors++;
        $display("FAIL settle_capture round=%0d got yv=%b out=%b src=%0d exp 1 %b 0",
                 r, y_valid1, y_out1, y_src1, ~noty1);
      end
      tick(1);
    end
  endtask

  task automatic test_prio0();
    int cyc;
    bit ok;
    do_reset();
    d = 4'b1010;
    sb.push_back({2'd1, 1'b1});
`ifdef MUX_SCHED_PRIO0_EN
    sb.push_back({2'd0, 1'b0});
    sb.push_back({2'd2, 1'b0});
`else
    sb.push_back({2'd2, 1'b0});
    sb.push_back({2'd3, 1'b1});
`endif
    req = 4'b1110;
    for (int r = 0; r < 3; r++) begin
      wait_valid(cyc, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL prio_timeout round=%0d", r);
      end else if (cyc != 4) begin
        errors++;
        $display("FAIL prio_spacing round=%0d got %0d exp 4", r, cyc);
      end
      if (r == 0) req = 4'b1111;
      else if (r == 1) req = 4'b1110;
      else req = 4'b0000;
    end
    tick(3);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_req_drop();
    test_settle_boundary();
    test_prio0();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_results got %0d pending exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_sched.md
Name: mux_rr_sched

Overview:
- Round-robin scheduler that shares one MUXX 4:1 inverting multiplexer between four requesters.
- Drives the mux select lines A1/A0, holds the select for a programmable settle time, samples notY, and returns the re-inverted data bit tagged with the serviced requester index.
- Sits between the requester logic and the MUXX instance; it is the only driver of A0/A1.

Parameters:
- SETTLE_CYCLES, 2, number of SETTLE-state cycles after select is driven before capture; legal range 1..15; 0 is illegal.
- CNT_W, 4, width of the internal settle counter; must hold SETTLE_CYCLES-1.

Ports:
- CLK  input  1  system clock; all state updates on rising edge
- RST  input  1  synchronous, active-high reset
- REQ  input  4  level request, bit i = requester i wants a sample of mux input Di
- NOTY  input  1  notY from the MUXX instance
- A0  output  1  mux select LSB (registered)
- A1  output  1  mux select MSB (registered)
- GNT  output  4  one-hot grant, high for the whole service of the winner
- BUSY  output  1  high while a service is in progress (SETTLE or CAPTURE)
- Y_VALID  output  1  one-cycle pulse: Y_OUT/Y_SRC hold a new result
- Y_OUT  output  1  captured data = ~NOTY at the capture edge
- Y_SRC  output  2  index of the requester whose result is on Y_OUT

Behaviour:
- Reset (RST=1 at an edge, regardless of state): A0=A1=0, GNT=0, BUSY=0, Y_VALID=0, Y_OUT=0, Y_SRC=0, priority pointer PRI=0, state=IDLE, counter=0. Reset mid-service aborts with no Y_VALID.
- States: IDLE, SETTLE, CAPTURE.
- IDLE, REQ==0: outputs hold; A1/A0 keep their last value; Y_VALID cleared.
- IDLE, REQ!=0:
  - Winner w = first set bit scanning PRI, PRI+1, ... mod 4.
  - At the edge: {A1,A0}<=w, GNT<=onehot(w), BUSY<=1, counter<=SETTLE_CYCLES-1, go to SETTLE.
- SETTLE: counter==0 -> CAPTURE; otherwise counter decrements. REQ is ignored.
- CAPTURE edge:
  - Y_OUT<=~NOTY, Y_SRC<=w, Y_VALID<=1.
  - GNT<=0, BUSY<=0, PRI<=(w+1) mod 4, go to IDLE.
  - A1/A0 unchanged.
- Y_VALID is high exactly one cycle; Y_OUT/Y_SRC hold until the next capture.
- Timing (arbitration edge t0):
  - Select stable from t0; NOTY sampled at edge t0+SETTLE_CYCLES+1, i.e. select held SETTLE_CYCLES+1 cycles before sampling.
  - Next arbitration no earlier than edge t0+SETTLE_CYCLES+2; back-to-back throughput is 1 result per SETTLE_CYCLES+2 cycles.
- REQ drop mid-service: the service still completes and produces a result. A requester holding REQ continuously is served again in its round-robin turn.
- Simultaneous requests: strict round-robin from PRI. Each requester is starved for at most 3 services.
- Y_VALID from a CAPTURE and a new arbitration cannot coincide, because IDLE always separates them.

Optional Feature:
- Macro MUX_SCHED_PRIO0_EN.
- Defined: requester 0 has fixed top priority. If REQ[0]=1 in IDLE, w=0 regardless of PRI, and PRI is not updated after serving 0. Requesters 1..3 arbitrate round-robin among themselves using PRI, skipping index 0.
- Undefined: pure 4-way round-robin as in Behaviour; no extra logic.

Test Plan:
- Reset: RST=1 for 2 cycles in SETTLE with REQ=4'b1111 -> A0=A1=0, GNT=0, BUSY=0, Y_VALID=0, no result pulse after release until a full service.
- Single request, SETTLE_CYCLES=2: REQ=4'b0100, mux D2=1 (NOTY=0) -> GNT=4'b0100 and {A1,A0}=2'b10 after t0; Y_VALID high one cycle after edge t0+3 with Y_OUT=1, Y_SRC=2.
- Round robin: REQ=4'b1111 held, D=4'b1010 -> Y_SRC sequence 0,1,2,3,0 with Y_OUT 0,1,0,1,0; Y_VALID spacing 4 cycles.
- REQ drop: REQ=4'b0010 pulsed for 1 cycle -> full service still completes, Y_SRC=1, one Y_VALID, then IDLE with GNT=0.
- Settle boundary: SETTLE_CYCLES=1, NOTY toggles at the edge before capture -> Y_OUT equals ~NOTY at edge t0+2 only.
- With MUX_SCHED_PRIO0_EN: REQ=4'b1110 held, REQ[0] raised after the first service -> requester 0 served next, then round-robin resumes at the pointer left by the 1..3 service.
